multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences instruction fetch, register-file decode/read, ALU execute, memory access and register-file writeback. It drives every enable and mux select of the shared PC/IR/ALU/memory/register-file datapath, and handshakes with a variable-latency memory. It also counts retired instructions and halts on a memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for MemReady in FETCH or MEM before halting (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
Ins  in  32  current IR contents; valid from DECODE onward
MemReady  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU branch condition true
PCSource  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target, 3=Rdata1 (JR)
IRWrite  out  1  load IR from memory data
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IorD  out  1  0=PC address, 1=ALUOut address
RegWrite  out  1  register-file write enable
RegDst  out  2  0=Ins[20:16], 1=Ins[15:11], 2=5'd31
MemToReg  out  2  0=ALUOut, 1=MDR, 2=PC (link)
ALUSrcA  out  1  0=PC, 1=Rdata1
ALUSrcB  out  2  0=Rdata2, 1=const 4, 2=Ed32, 3=Ed32<<2
ALUOp  out  2  0=add, 1=branch compare, 2=R-type funct, 3=I-type opcode
State  out  3  current state (debug)
InsDone  out  1  one-cycle pulse when an instruction retires
InsCount  out  CNT_W  retired instruction count
Illegal  out  1  one-cycle pulse on unsupported opcode
Halted  out  1  high in HALT

Behaviour:
- Opcodes: R_FORM=0 (funct JR=8), J=2, JAL=3, BEQ=4, BNE=5, BLEZ=6, BGTZ=7, I-ALU=8..15, LW=35, SW=43. Any other opcode is illegal.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. State is registered; outputs are combinational from State and Ins.
- Default value of every control output is 0.
- RST: State<=FETCH, InsCount<=0, wait counter<=0. While RST=1 all control outputs and pulses are forced to 0. Reset mid-instruction abandons it without retiring.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0. When MemReady=1: IRWrite=1, PCWrite=1, PCSource=0, next state DECODE. Otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut).
  - J: PCWrite=1, PCSource=2, retire, next FETCH.
  - JR: PCWrite=1, PCSource=3, retire, next FETCH.
  - Illegal opcode: Illegal=1, no retire, next FETCH.
  - All other opcodes: next EXEC.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=0, ALUOp=2, next WB.
  - I-ALU: ALUSrcA=1, ALUSrcB=2, ALUOp=3, next WB.
  - LW/SW: ALUSrcA=1, ALUSrcB=2, ALUOp=0, next MEM.
  - Branch: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, retire, next FETCH.
  - JAL: RegWrite=1, RegDst=2, MemToReg=2, PCWrite=1, PCSource=2, retire, next FETCH.
- MEM: IorD=1; LW asserts MemRead, SW asserts MemWrite. Requests are held until MemReady=1. On MemReady, LW goes to WB; SW retires and goes to FETCH.
- WB: RegWrite=1. RegDst=1 for R-type, 0 otherwise. MemToReg=1 for LW, 0 otherwise. Retire, next FETCH.
- Retire: InsDone=1 for exactly that cycle and InsCount increments at the clock edge. InsCount wraps modulo 2^CNT_W.
- Timeout: the wait counter clears on entering FETCH or MEM and increments on each MemReady=0 cycle there. When it reaches MEM_TIMEOUT with MemReady still 0, next state is HALT. If MemReady=1 in the same cycle, the transfer completes normally.
- HALT: all control outputs 0, Halted=1. Only RST exits HALT.
- Latency with MemReady=1 throughout: R-type/I-ALU 4 cycles, LW 5, SW 4, branch/JAL 3, J/JR 2.

Test Plan:
- Reset then addu $3,$1,$2 (0x00221821), MemReady=1 -> states 0,1,2,4. In WB: RegWrite=1, RegDst=1, MemToReg=0. InsDone pulses once and InsCount=1.
- lw $5,4($0) (0x8C050004) with MemReady low 2 cycles in FETCH and 2 in MEM -> 9 cycles total. MemRead is held and IorD=1 in MEM. WB has RegDst=0, MemToReg=1.
- Back-to-back sw (0xAC050008), beq (0x10000003), jal (0x0C000010) -> SW: MemWrite with no RegWrite. BEQ EXEC: PCWriteCond=1, PCSource=1. JAL EXEC: RegWrite=1, RegDst=2, MemToReg=2, PCSource=2. InsCount=3.
- Opcode 0x3F in IR -> Illegal pulse in DECODE, no InsDone, next state FETCH. J (0x08000000) retires after 2 cycles.
- MemReady held 0 in FETCH, MEM_TIMEOUT=16 -> HALT entered after the 16th wait cycle with Halted=1 and all controls 0. Stays halted for 100 cycles; RST recovers to FETCH with InsCount=0.
- RST asserted in MEM of an LW -> next cycle State=FETCH, no InsDone, no RegWrite issued.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for the multicycle MIPS datapath.
// Sequences fetch, decode, execute, memory and writeback. It drives every
// datapath enable and mux select, waits on a variable-latency memory, counts
// retired instructions and halts if the memory stops answering.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      Ins,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IRWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             RegWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       State,
  output logic             InsDone,
  output logic [CNT_W-1:0] InsCount,
  output logic             Illegal,
  output logic             Halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // The wait counter only needs to reach MEM_TIMEOUT-1: the cycle that would
  // push it to MEM_TIMEOUT is the one that decides to halt.
  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t state, nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic timedOut;

  logic [5:0] opcode, funct;
  logic isRForm, isJr, isRType, isJ, isJal, isBranch, isIAlu, isLw, isSw;
  logic isLegal;
  logic unusedInsBits;

  assign opcode   = Ins[31:26];
  assign funct    = Ins[5:0];
  assign isRForm  = (opcode == 6'd0);
  assign isJr     = isRForm && (funct == 6'd8);
  assign isRType  = isRForm && (funct != 6'd8);
  assign isJ      = (opcode == 6'd2);
  assign isJal    = (opcode == 6'd3);
  assign isBranch = (opcode[5:2] == 4'b0001);
  assign isIAlu   = (opcode[5:3] == 3'b001);
  assign isLw     = (opcode == 6'd35);
  assign isSw     = (opcode == 6'd43);
  assign isLegal  = isRForm | isJ | isJal | isBranch | isIAlu | isLw | isSw;
  assign unusedInsBits = ^Ins[25:6];

  assign timedOut = !MemReady && (waitCnt == WAIT_LAST);
  assign State    = state;

  // Next-state and control decode; reset holds every control output low.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'd0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'd0;
    MemToReg    = 2'd0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    ALUOp       = 2'd0;
    InsDone     = 1'b0;
    Illegal     = 1'b0;
    Halted      = 1'b0;
    nextState   = state;
    if (RST) begin
      nextState = FETCH;
    end else begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          if (MemReady) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            nextState = DECODE;
          end else if (timedOut) begin
            nextState = HALT;
          end
        end
        DECODE: begin
          ALUSrcB = 2'd3;
          if (isJ) begin
            PCWrite   = 1'b1;
            PCSource  = 2'd2;
            InsDone   = 1'b1;
            nextState = FETCH;
          end else if (isJr) begin
            PCWrite   = 1'b1;
            PCSource  = 2'd3;
            InsDone   = 1'b1;
            nextState = FETCH;
          end else if (!isLegal) begin
            Illegal   = 1'b1;
            nextState = FETCH;
          end else begin
            nextState = EXEC;
          end
        end
        EXEC: begin
          nextState = FETCH;
          if (isRType) begin
            ALUSrcA   = 1'b1;
            ALUOp     = 2'd2;
            nextState = WB;
          end else if (isIAlu) begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'd2;
            ALUOp     = 2'd3;
            nextState = WB;
          end else if (isLw || isSw) begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'd2;
            nextState = MEM;
          end else if (isBranch) begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'd1;
            PCWriteCond = 1'b1;
            PCSource    = 2'd1;
            InsDone     = 1'b1;
          end else if (isJal) begin
            RegWrite = 1'b1;
            RegDst   = 2'd2;
            MemToReg = 2'd2;
            PCWrite  = 1'b1;
            PCSource = 2'd2;
            InsDone  = 1'b1;
          end
        end
        MEM: begin
          IorD     = 1'b1;
          MemRead  = isLw;
          MemWrite = isSw;
          if (MemReady) begin
            if (isLw) begin
              nextState = WB;
            end else begin
              InsDone   = 1'b1;
              nextState = FETCH;
            end
          end else if (timedOut) begin
            nextState = HALT;
          end
        end
        WB: begin
          RegWrite  = 1'b1;
          RegDst    = isRType ? 2'd1 : 2'd0;
          MemToReg  = isLw ? 2'd1 : 2'd0;
          InsDone   = 1'b1;
          nextState = FETCH;
        end
        HALT: begin
          Halted = 1'b1;
        end
        default: begin
          nextState = FETCH;
        end
      endcase
    end
  end

  // State register plus the memory wait counter, which restarts whenever
  // FETCH or MEM is entered and advances while the memory keeps us waiting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= FETCH;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (((state == FETCH) || (state == MEM)) && (nextState == state)) begin
        waitCnt <= waitCnt + 1'b1;
      end else begin
        waitCnt <= '0;
      end
    end
  end

  // Retired-instruction counter, wrapping naturally at its width.
  always_ff @(posedge CLK) begin
    if (RST) begin
      InsCount <= '0;
    end else if (InsDone) begin
      InsCount <= InsCount + 1'b1;
    end
  end

endmodule
